// File: rtl/ras_ckpt.sv
// ras_ckpt: return address stack for the fetch-stage predictor.
// Each predicted jump is classified as a call, a return or a coroutine swap,
// using x1/x5 as the link registers. The stack is circular with DEPTH entries.
// Up to CKPT snapshots of {tos, count, top entry} can be taken at predicted
// branches. On a mispredict, restoring a snapshot repairs both the pointer and
// the top entry.
//
// Build option: define RAS_COROUTINE_EN to build the coroutine swap datapath.
// When it is undefined, swap encodings are handled as plain calls.
module ras_ckpt #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 8,
    parameter int CKPT  = 4,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = $clog2(DEPTH + 1),
    localparam int CKPT_W = $clog2(CKPT)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              jump_valid,
    input  logic [6:0]        opcode,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [XLEN-1:0]   return_address,
    input  logic              ckpt_save,
    input  logic [CKPT_W-1:0] ckpt_save_id,
    input  logic              restore_en,
    input  logic [CKPT_W-1:0] restore_id,
    output logic [XLEN-1:0]   top_address,
    output logic              top_valid,
    output logic [CNT_W-1:0]  count_out,
    output logic [PTR_W-1:0]  tos_ptr_out,
    output logic              overflow,
    output logic              underflow
);

    // RV32 jump opcodes (same values as OP_J_JAL / OP_J_JALR in isa.v)
    localparam logic [6:0] OP_J_JAL  = 7'b1101111;
    localparam logic [6:0] OP_J_JALR = 7'b1100111;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [XLEN-1:0]   stack  [DEPTH];
    logic [PTR_W-1:0]  tos;
    logic [CNT_W-1:0]  count;

    logic [PTR_W-1:0]  ck_tos [CKPT];
    logic [CNT_W-1:0]  ck_cnt [CKPT];
    logic [XLEN-1:0]   ck_top [CKPT];

    logic link_rd;
    logic link_rs1;
    logic is_call;
    logic is_ret;
    logic is_swap;
    logic do_push;
    logic do_pop;
`ifdef RAS_COROUTINE_EN
    logic do_swap;
`endif

    function automatic logic is_link(input logic [4:0] r);
        return (r == 5'd1) || (r == 5'd5);
    endfunction

    // DEPTH is a power of two, so the pointer wraps naturally in PTR_W bits
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return p + PTR_W'(1);
    endfunction

    function automatic logic [PTR_W-1:0] ptr_dec(input logic [PTR_W-1:0] p);
        return p - PTR_W'(1);
    endfunction

    function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_FULL) ? c : c + CNT_W'(1);
    endfunction

    // Classify the predicted jump into push / pop / swap
    always_comb begin
        link_rd  = is_link(rd);
        link_rs1 = is_link(rs1);
        is_call  = jump_valid &&
                   (((opcode == OP_J_JAL) && link_rd) ||
                    ((opcode == OP_J_JALR) && link_rd && (!link_rs1 || (rd == rs1))));
        is_ret   = jump_valid && (opcode == OP_J_JALR) && link_rs1 && !link_rd;
        is_swap  = jump_valid && (opcode == OP_J_JALR) && link_rd && link_rs1 && (rd != rs1);
        do_pop   = is_ret;
`ifdef RAS_COROUTINE_EN
        // A swap on an empty stack has no top entry to replace, so it pushes instead
        do_swap  = is_swap && (count != '0);
        do_push  = is_call || (is_swap && (count == '0));
`else
        do_push  = is_call || is_swap;
`endif
    end

    // Stack, pointer, snapshot and pulse state; restore and flush override jumps
    always_ff @(posedge clk) begin
        if (!reset) begin
            tos       <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                stack[i] <= '0;
            end
            for (int j = 0; j < CKPT; j++) begin
                ck_tos[j] <= '0;
                ck_cnt[j] <= '0;
                ck_top[j] <= '0;
            end
        end else begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
            if (flush) begin
                tos   <= '0;
                count <= '0;
            end else if (restore_en) begin
                tos   <= ck_tos[restore_id];
                count <= ck_cnt[restore_id];
                stack[ck_tos[restore_id]] <= ck_top[restore_id];
            end else begin
                // The snapshot sees the state from before this cycle's jump
                if (ckpt_save) begin
                    ck_tos[ckpt_save_id] <= tos;
                    ck_cnt[ckpt_save_id] <= count;
                    ck_top[ckpt_save_id] <= stack[tos];
                end
                if (do_push) begin
                    tos               <= ptr_inc(tos);
                    stack[ptr_inc(tos)] <= return_address;
                    count             <= cnt_sat_inc(count);
                    overflow          <= (count == CNT_FULL);
                end else if (do_pop) begin
                    if (count != '0) begin
                        tos   <= ptr_dec(tos);
                        count <= count - CNT_W'(1);
                    end else begin
                        underflow <= 1'b1;
                    end
                end
`ifdef RAS_COROUTINE_EN
                else if (do_swap) begin
                    stack[tos] <= return_address;
                end
`endif
            end
        end
    end

    assign top_address = stack[tos];
    assign top_valid   = (count != '0);
    assign count_out   = count;
    assign tos_ptr_out = tos;

endmodule

// File: doc/ras_ckpt.md
# ras_ckpt

Parametrised return address stack with speculative checkpoint/restore, for the fetch-stage predictor. Classifies each predicted jump as call, return or coroutine swap from opcode/rd/rs1 (link registers x1/x5). Circular stack of DEPTH entries. Up to CKPT snapshots are taken at predicted branches; on a mispredict the branch unit restores a snapshot, repairing both the pointer and the top entry.

## Interface
Parameters:
- XLEN, 32, address width
- DEPTH, 8, stack entries; power of two, ≥2
- CKPT, 4, checkpoint slots; power of two, ≥2
- Derived widths: PTR_W=$clog2(DEPTH), CNT_W=$clog2(DEPTH+1), CKPT_W=$clog2(CKPT)

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-low
- flush  in  1  empty the stack (pipeline flush)
- jump_valid  in  1  opcode/rd/rs1 describe a predicted jump this cycle
- opcode  in  7  compared against `OP_J_JAL` / `OP_J_JALR` from isa.v
- rd  in  5  destination register
- rs1  in  5  source register
- return_address  in  XLEN  value pushed on call (PC+4)
- ckpt_save  in  1  take snapshot into slot ckpt_save_id
- ckpt_save_id  in  CKPT_W  snapshot slot
- restore_en  in  1  restore snapshot restore_id
- restore_id  in  CKPT_W  slot to restore
- top_address  out  XLEN  stack[tos], predicted return target
- top_valid  out  1  count != 0
- count_out  out  CNT_W  live entries, 0..DEPTH
- tos_ptr_out  out  PTR_W  index of top entry
- overflow  out  1  registered 1-cycle pulse: a push dropped the oldest entry
- underflow  out  1  registered 1-cycle pulse: return seen with count==0

## Operation
- link(r) = (r==1 || r==5).
- call: JAL with link(rd), or JALR with link(rd) and (!link(rs1) or rd==rs1).
- return: JALR with link(rs1) and !link(rd).
- swap: JALR with link(rd), link(rs1), rd!=rs1.
- Push: tos <= tos+1 mod DEPTH; stack[tos+1] <= return_address; count <= min(count+1, DEPTH). If count==DEPTH, the oldest entry is overwritten and overflow pulses.
- Pop: if count>0, tos <= tos-1 mod DEPTH and count-1. If count==0, no state change and underflow pulses.
- Swap: stack[tos] <= return_address; tos unchanged. If count==0, acts as a push (count becomes 1).
- Snapshot slot holds {tos, count, stack[tos]}. It captures the registered state from before any same-cycle jump update.
- Restore: tos and count are loaded from the slot, and stack[slot.tos] <= slot.top. The same-cycle jump is ignored, and so is a same-cycle ckpt_save.
- Priority: reset > flush > restore_en > ckpt_save / jump. Save and jump coexist in one cycle.
- flush: tos=0, count=0; stack contents and snapshots are retained, not cleared.
- Reset clears tos, count, every stack entry, every snapshot, overflow and underflow.
- Reset values of outputs: top_address=0, top_valid=0, count_out=0, tos_ptr_out=0, overflow=0, underflow=0.

## Timing
- top_address, top_valid, count_out and tos_ptr_out are combinational from registered state. No input-to-output combinational path.
- Push, pop, swap, restore and flush become visible on the outputs the cycle after the input is sampled. Latency is 1.
- Back-to-back operations every cycle are supported with no bubbles.
- Wrap-around:
  - tos goes DEPTH-1 → 0 on push.
  - tos goes 0 → DEPTH-1 on pop.
  - count saturates at DEPTH and never goes below 0.
- Restoring a slot that was never saved restores its reset contents (empty stack).
- Reset asserted mid-sequence: state is cleared at the next edge, and pending restores and saves are discarded.

## Configuration
- `RAS_COROUTINE_EN` defined: swap behaves as described above.
- `RAS_COROUTINE_EN` undefined:
  - swap encodings are classified as a plain call (push only).
  - the swap datapath is not built.

## Test plan
- DEPTH=4, reset low 2 cycles then high → all outputs 0. Push 0x100, 0x104, 0x108 → top_address=0x108, count_out=3, tos_ptr_out=3.
- Push 5 addresses 0x10..0x50 into an empty DEPTH=4 stack → the 5th push pulses overflow. Then count=4, top=0x50; four pops return 0x40, 0x30, 0x20; then top_valid=0.
- Pop on an empty stack → underflow pulses 1 cycle; tos and count unchanged.
- Stack {0x100, 0x200}; ckpt_save id 1; pop; then push 0x300 (overwrites the 0x200 slot); restore_en id 1 → top=0x200, count=2.
- With `RAS_COROUTINE_EN`: stack top 0x200, JALR rd=x1 rs1=x5, return_address=0x400 → top=0x400, count unchanged. Without the macro the same stimulus gives count+1, top=0x400, and the old 0x200 is still below it.
- Same cycle: flush + restore_en + push → stack empty next cycle. Same cycle: restore_en + push → restored state only.
